// File: rtl/video_jb_ctrl_if.sv
// rtl/video_jb_ctrl_if.sv - OSD/sync inputs and overlay outputs of the jailbar sequencer
interface video_jb_ctrl_if;
  logic [1:0]  mode_req;
  logic [5:0]  phase_req;
  logic        hsync;
  logic        vsync;
  logic [1:0]  mode_o;
  logic [5:0]  preset_o;
  logic        hs_pulse;
  logic        locked;
  logic [11:0] line_len;

  modport master (
    output mode_req, phase_req, hsync, vsync,
    input  mode_o, preset_o, hs_pulse, locked, line_len
  );

  modport slave (
    input  mode_req, phase_req, hsync, vsync,
    output mode_o, preset_o, hs_pulse, locked, line_len
  );
endinterface

// File: rtl/video_jb_ctrl.sv
// rtl/video_jb_ctrl.sv - hsync lock qualifier and frame-aligned config loader for the jailbar overlay
module video_jb_ctrl #(
  parameter logic [11:0] MIN_LINE   = 12'd256,
  parameter logic [11:0] MAX_LINE   = 12'd4000,
  parameter logic [3:0]  TOL        = 4'd4,
  parameter logic [3:0]  LOCK_LINES = 4'd8,
  parameter logic [5:0]  PRESET     = 6'd24
) (
  input logic            clk,
  input logic            reset_n,
  video_jb_ctrl_if.slave vif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state;
  logic               hs_d;
  logic               vs_d;
  logic [11:0]        pcnt;
  logic [3:0]         match_cnt;
  logic [1:0]         mode_r;
  logic [5:0]         preset_r;
  logic               hs_pulse_r;
  logic               locked_r;
  logic [11:0]        line_len_r;

  logic               hs_edge;
  logic               vs_edge;
  logic               m_valid;
  logic               match;
  logic               pcnt_sat;
  logic signed [12:0] diff;
  logic [12:0]        adiff;
  logic [3:0]         cnt_inc;

  // pcnt is the measured period m at the moment an hsync edge is seen
  assign hs_edge  = vif.hsync & ~hs_d;
  assign vs_edge  = vif.vsync & ~vs_d;
  assign pcnt_sat = (pcnt == MAX_LINE);
  assign m_valid  = (pcnt >= MIN_LINE) && (pcnt < MAX_LINE);
  assign diff     = $signed({1'b0, pcnt}) - $signed({1'b0, line_len_r});
  assign adiff    = diff[12] ? $unsigned(-diff) : $unsigned(diff);
  assign match    = (adiff <= {9'd0, TOL});
  assign cnt_inc  = match_cnt + 4'd1;

  assign vif.mode_o   = mode_r;
  assign vif.preset_o = preset_r;
  assign vif.hs_pulse = hs_pulse_r;
  assign vif.locked   = locked_r;
  assign vif.line_len = line_len_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SEARCH;
      hs_d       <= 1'b0;
      vs_d       <= 1'b0;
      pcnt       <= 12'd0;
      match_cnt  <= 4'd0;
      mode_r     <= 2'd0;
      preset_r   <= PRESET;
      hs_pulse_r <= 1'b0;
      locked_r   <= 1'b0;
      line_len_r <= 12'd0;
    end else begin
      hs_d       <= vif.hsync;
      vs_d       <= vif.vsync;
      hs_pulse_r <= hs_edge;

      if (hs_edge) begin
        pcnt <= 12'd1;
      end else if (!pcnt_sat) begin
        pcnt <= pcnt + 12'd1;
      end

      case (state)
        SEARCH: begin
          locked_r <= 1'b0;
          mode_r   <= 2'd0;
          // The first edge only starts the period counter; nothing to measure yet
          if (hs_edge) begin
            state     <= TRACK;
            match_cnt <= 4'd0;
          end
        end

        TRACK: begin
          locked_r <= 1'b0;
          mode_r   <= 2'd0;
          if (hs_edge) begin
            if (m_valid) begin
              line_len_r <= pcnt;
              if ((match_cnt == 4'd0) || match) begin
                if (cnt_inc == LOCK_LINES) begin
                  state     <= LOCKED;
                  locked_r  <= 1'b1;
                  match_cnt <= 4'd0;
                end else begin
                  match_cnt <= cnt_inc;
                end
              end else begin
                match_cnt <= 4'd1;
              end
            end else begin
              match_cnt <= 4'd0;
            end
          end else if (pcnt_sat) begin
            state     <= SEARCH;
            match_cnt <= 4'd0;
          end
        end

        LOCKED: begin
          // Lock decision precedes the frame-boundary config load
          if (hs_edge && !(m_valid && match)) begin
            state     <= TRACK;
            match_cnt <= 4'd0;
            locked_r  <= 1'b0;
            mode_r    <= 2'd0;
          end else if (!hs_edge && pcnt_sat) begin
            state     <= SEARCH;
            match_cnt <= 4'd0;
            locked_r  <= 1'b0;
            mode_r    <= 2'd0;
          end else begin
            locked_r <= 1'b1;
            if (hs_edge) begin
              line_len_r <= pcnt;
            end
            if (vs_edge) begin
              mode_r   <= vif.mode_req;
              preset_r <= PRESET + vif.phase_req;
            end
          end
        end

        default: begin
          state     <= SEARCH;
          match_cnt <= 4'd0;
          locked_r  <= 1'b0;
          mode_r    <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_jb_ctrl.sv
// tb/tb_video_jb_ctrl.sv - table-driven and randomized bench for video_jb_ctrl
module tb_video_jb_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  video_jb_ctrl_if vif();

  video_jb_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vif     (vif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;
  int pulse_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: period = cycles since the previous hsync rise, kept as an unbounded integer
  int         age;
  int         m;
  int         run;
  bit         hs_prev, vs_prev, hs_e, vs_e, valid, close, tracking;
  logic [1:0] e_mode;
  logic [5:0] e_preset;
  logic       e_pulse;
  logic       e_locked;
  int         e_len;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      age = 0; run = 0; hs_prev = 0; vs_prev = 0; tracking = 0;
      e_mode = 0; e_preset = 6'd24; e_pulse = 0; e_locked = 0; e_len = 0;
    end else begin
      hs_e = vif.hsync && !hs_prev;
      vs_e = vif.vsync && !vs_prev;
      hs_prev = vif.hsync;
      vs_prev = vif.vsync;
      e_pulse = hs_e;
      m = age;
      age = hs_e ? 1 : age + 1;
      valid = (m >= 256) && (m < 4000);
      close = valid && ((m > e_len ? m - e_len : e_len - m) <= 4);
      if (e_locked) begin
        if (hs_e && close) begin
          e_len = m;
          if (vs_e) begin e_mode = vif.mode_req; e_preset = 6'((24 + vif.phase_req) % 64); end
        end else if (hs_e) begin
          e_locked = 0; tracking = 1; run = 0; e_mode = 0;
        end else if (m >= 4000) begin
          e_locked = 0; tracking = 0; e_mode = 0;
        end else if (vs_e) begin
          e_mode = vif.mode_req; e_preset = 6'((24 + vif.phase_req) % 64);
        end
      end else if (tracking) begin
        if (hs_e) begin
          if (valid) begin
            run = (run == 0 || close) ? run + 1 : 1;
            e_len = m;
            if (run == 8) begin e_locked = 1; tracking = 0; end
          end else begin
            run = 0;
          end
        end else if (m >= 4000) begin
          tracking = 0;
        end
      end else if (hs_e) begin
        tracking = 1; run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (vif.hs_pulse === 1'b1) pulse_cnt++;
    if (chk_on) begin
      n_checks++;
      if ({vif.mode_o, vif.preset_o, vif.hs_pulse, vif.locked, vif.line_len} ===
          {e_mode, e_preset, e_pulse, e_locked, e_len[11:0]}) n_pass++;
      else $display("FAIL model t=%0t mode %0d/%0d preset %0d/%0d pulse %0d/%0d locked %0d/%0d len %0d/%0d",
                    $time, vif.mode_o, e_mode, vif.preset_o, e_preset, vif.hs_pulse, e_pulse,
                    vif.locked, e_locked, vif.line_len, e_len);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // vs: 0 none, 1 vsync mid-line, 2 vsync rising together with the closing hsync
  task automatic drive_line(input int p, input int vs);
    for (int i = 0; i < p; i++) begin
      vif.hsync = (i >= p - 2);
      vif.vsync = ((vs == 1) && (i == 10 || i == 11)) || ((vs == 2) && (i >= p - 2));
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      vif.hsync = 1'b0;
      vif.vsync = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int         period;
    int         count;
    logic [1:0] mreq;
    logic [5:0] preq;
    int         vs;
    logic       e_locked;
    logic [1:0] e_mode;
    logic [5:0] e_preset;
    logic [11:0] e_len;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl[NV];
  int   p0, base, cur, p, vs, r;

  initial begin
    tbl[0]  = '{1000, 9,  2'd3, 6'd5,  0, 1'b1, 2'd0, 6'd24, 12'd1000};
    tbl[1]  = '{1000, 1,  2'd3, 6'd5,  1, 1'b1, 2'd3, 6'd29, 12'd1000};
    tbl[2]  = '{999,  1,  2'd3, 6'd5,  0, 1'b1, 2'd3, 6'd29, 12'd999};
    tbl[3]  = '{1003, 1,  2'd3, 6'd5,  0, 1'b1, 2'd3, 6'd29, 12'd1003};
    tbl[4]  = '{999,  1,  2'd3, 6'd5,  0, 1'b1, 2'd3, 6'd29, 12'd999};
    tbl[5]  = '{1003, 1,  2'd3, 6'd5,  0, 1'b1, 2'd3, 6'd29, 12'd1003};
    tbl[6]  = '{1010, 1,  2'd3, 6'd5,  0, 1'b0, 2'd0, 6'd29, 12'd1003};
    tbl[7]  = '{1000, 7,  2'd3, 6'd5,  0, 1'b0, 2'd0, 6'd29, 12'd1000};
    tbl[8]  = '{1000, 1,  2'd3, 6'd5,  0, 1'b1, 2'd0, 6'd29, 12'd1000};
    tbl[9]  = '{1000, 1,  2'd3, 6'd5,  1, 1'b1, 2'd3, 6'd29, 12'd1000};
    tbl[10] = '{1000, 1,  2'd1, 6'd50, 0, 1'b1, 2'd3, 6'd29, 12'd1000};
    tbl[11] = '{1000, 1,  2'd1, 6'd50, 1, 1'b1, 2'd1, 6'd10, 12'd1000};
    tbl[12] = '{1005, 1,  2'd2, 6'd0,  2, 1'b0, 2'd0, 6'd10, 12'd1000};
    tbl[13] = '{1000, 8,  2'd2, 6'd0,  0, 1'b1, 2'd0, 6'd10, 12'd1000};
    tbl[14] = '{1002, 1,  2'd2, 6'd0,  2, 1'b1, 2'd2, 6'd24, 12'd1002};
    tbl[15] = '{4100, 0,  2'd2, 6'd0,  0, 1'b0, 2'd0, 6'd24, 12'd1002};
    tbl[16] = '{100,  12, 2'd1, 6'd7,  0, 1'b0, 2'd0, 6'd24, 12'd1002};
    tbl[17] = '{255,  9,  2'd1, 6'd7,  0, 1'b0, 2'd0, 6'd24, 12'd1002};
    tbl[18] = '{256,  8,  2'd1, 6'd7,  0, 1'b1, 2'd0, 6'd24, 12'd256};
    tbl[19] = '{4000, 1,  2'd1, 6'd7,  0, 1'b0, 2'd0, 6'd24, 12'd256};
    tbl[20] = '{3999, 1,  2'd1, 6'd7,  0, 1'b0, 2'd0, 6'd24, 12'd3999};

    reset_n = 1'b0;
    vif.hsync = 1'b0; vif.vsync = 1'b0; vif.mode_req = 2'd3; vif.phase_req = 6'd5;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vif.hsync = i[0];
      vif.vsync = i[1];
      @(negedge clk);
    end
    chk("reset mode_o", vif.mode_o, 2'd0);
    chk("reset preset_o", vif.preset_o, 6'd24);
    chk("reset locked", vif.locked, 1'b0);
    chk("reset hs_pulse", vif.hs_pulse, 1'b0);
    chk("reset line_len", vif.line_len, 12'd0);
    vif.hsync = 1'b0; vif.vsync = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      vif.mode_req  = tbl[k].mreq;
      vif.phase_req = tbl[k].preq;
      p0 = pulse_cnt;
      if (tbl[k].count == 0) idle(tbl[k].period);
      else for (int j = 0; j < tbl[k].count; j++)
        drive_line(tbl[k].period, (j == tbl[k].count - 1) ? tbl[k].vs : 0);
      chk($sformatf("row%0d locked", k), vif.locked, tbl[k].e_locked);
      chk($sformatf("row%0d mode_o", k), vif.mode_o, tbl[k].e_mode);
      chk($sformatf("row%0d preset_o", k), vif.preset_o, tbl[k].e_preset);
      chk($sformatf("row%0d line_len", k), vif.line_len, tbl[k].e_len);
      chk($sformatf("row%0d hs_pulses", k), pulse_cnt - p0, tbl[k].count);
    end

    // Relock, load a config, then hit reset in the middle of a line
    vif.mode_req = 2'd2; vif.phase_req = 6'd9;
    for (int j = 0; j < 8; j++) drive_line(400, 0);
    drive_line(400, 1);
    chk("relock locked", vif.locked, 1'b1);
    chk("relock mode_o", vif.mode_o, 2'd2);
    chk("relock preset_o", vif.preset_o, 6'd33);
    idle(50);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset mode_o", vif.mode_o, 2'd0);
    chk("midreset preset_o", vif.preset_o, 6'd24);
    chk("midreset locked", vif.locked, 1'b0);
    chk("midreset line_len", vif.line_len, 12'd0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    base = $urandom_range(300, 400);
    cur  = base;
    for (int l = 0; l < 50; l++) begin
      r = $urandom_range(0, 59);
      vif.mode_req  = 2'($urandom_range(0, 3));
      vif.phase_req = 6'($urandom_range(0, 63));
      vs = $urandom_range(0, 5);
      if (vs > 2) vs = 0;
      if (r == 0) begin
        idle(4050);
      end else begin
        if (r == 1) p = $urandom_range(100, 255);
        else if (r < 4) p = cur + 5 + int'($urandom_range(0, 15));
        else begin
          cur = cur + int'($urandom_range(0, 4)) - 2;
          if (cur < base - 20) cur = base - 20;
          if (cur > base + 20) cur = base + 20;
          p = cur;
        end
        drive_line(p, vs);
      end
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
